// File: rtl/bk_save_if.sv
// Bus bundle for the backup-save controller: save control, HPS block-write
// handshake, transfer-buffer readout and the toggle-handshake SDRAM read port.
interface bk_save_if;
  logic        bk_save;
  logic [1:0]  img_mounted;
  logic [31:0] vol0_blocks;
  logic [31:0] vol1_blocks;
  logic [31:0] sd_lba;
  logic [1:0]  sd_wr;
  logic [1:0]  sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_din;
  logic [24:0] mem_raddr;
  logic        mem_rd_req;
  logic        mem_rd_ack;
  logic [15:0] mem_dout;
  logic        busy;
  logic        done;

  modport master (
    output bk_save, img_mounted, vol0_blocks, vol1_blocks, sd_ack, sd_buff_addr,
           mem_rd_ack, mem_dout,
    input  sd_lba, sd_wr, sd_buff_din, mem_raddr, mem_rd_req, busy, done
  );

  modport slave (
    input  bk_save, img_mounted, vol0_blocks, vol1_blocks, sd_ack, sd_buff_addr,
           mem_rd_ack, mem_dout,
    output sd_lba, sd_wr, sd_buff_din, mem_raddr, mem_rd_req, busy, done
  );
endinterface

// File: rtl/bk_save_ctrl.sv
// Copies mounted volume images from SDRAM to the HPS one 512-byte block at a time:
// fill a 256x16 buffer through the toggle read port, then hand it out via sd_wr.
module bk_save_ctrl #(
  parameter logic [24:0] SRAM_BASE_A = 25'h0,
  parameter logic [24:0] BMP_BASE_A  = 25'h0
) (
  input  logic      clk_sys,
  input  logic      reset,
  bk_save_if.slave  bus_io
);

  typedef enum logic [2:0] {
    StIdle,
    StSelectVd,
    StFillReq,
    StFillWait,
    StStartSdWr,
    StSdWr,
    StNextLba,
    StNextVd
  } state_e;

  state_e      state_q, state_d;
  logic        vd_q, vd_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] sd_lba_q, sd_lba_d;
  logic [1:0]  sd_wr_q, sd_wr_d;
  logic        mem_rd_req_q, mem_rd_req_d;
  logic [24:0] mem_raddr_q, mem_raddr_d;
  logic        done_q, done_d;
  logic        ack_q;

  logic        ack_any;
  logic        ack_rise;
  logic        ack_fall;
  logic        buf_we;
  logic [31:0] vol_blocks;
  logic [24:0] vol_base;
  logic [24:0] fill_addr;

  logic [15:0] buf_mem [256];
  logic [15:0] buf_rdata_q;

  // Edge detect against the registered copy, so rise and fall never coincide.
  assign ack_any  = |bus_io.sd_ack;
  assign ack_rise = ack_any & ~ack_q;
  assign ack_fall = ~ack_any & ack_q;

  assign vol_blocks = vd_q ? bus_io.vol1_blocks : bus_io.vol0_blocks;
  assign vol_base   = vd_q ? BMP_BASE_A : SRAM_BASE_A;
  // Only the low 16 LBA bits can reach a 25-bit byte address.
  assign fill_addr  = vol_base + {sd_lba_q[15:0], 9'b0} + {16'b0, idx_q, 1'b0};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= StIdle;
      vd_q         <= 1'b0;
      idx_q        <= 8'd0;
      sd_lba_q     <= 32'd0;
      sd_wr_q      <= 2'b00;
      mem_rd_req_q <= 1'b0;
      mem_raddr_q  <= 25'd0;
      done_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      vd_q         <= vd_d;
      idx_q        <= idx_d;
      sd_lba_q     <= sd_lba_d;
      sd_wr_q      <= sd_wr_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_raddr_q  <= mem_raddr_d;
      done_q       <= done_d;
      ack_q        <= ack_any;
    end
  end

  always_comb begin
    state_d      = state_q;
    vd_d         = vd_q;
    idx_d        = idx_q;
    sd_lba_d     = sd_lba_q;
    sd_wr_d      = sd_wr_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_raddr_d  = mem_raddr_q;
    done_d       = 1'b0;
    buf_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.bk_save) begin
          vd_d    = 1'b0;
          state_d = StSelectVd;
        end
      end
      StSelectVd: begin
        if (bus_io.img_mounted[vd_q] && (vol_blocks != 32'd0)) begin
          sd_lba_d = 32'd0;
          idx_d    = 8'd0;
          state_d  = StFillReq;
        end else begin
          state_d = StNextVd;
        end
      end
      StFillReq: begin
        mem_raddr_d  = fill_addr;
        mem_rd_req_d = ~mem_rd_req_q;
        state_d      = StFillWait;
      end
      StFillWait: begin
        if (bus_io.mem_rd_ack == mem_rd_req_q) begin
          buf_we = 1'b1;
          if (idx_q == 8'hff) begin
            state_d = StStartSdWr;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = StFillReq;
          end
        end
      end
      StStartSdWr: begin
        sd_wr_d = vd_q ? 2'b10 : 2'b01;
        state_d = StSdWr;
      end
      StSdWr: begin
        if (ack_rise) sd_wr_d = 2'b00;
        if (ack_fall) state_d = StNextLba;
      end
      StNextLba: begin
        if (sd_lba_q + 32'd1 == vol_blocks) begin
          state_d = StNextVd;
        end else begin
          sd_lba_d = sd_lba_q + 32'd1;
          idx_d    = 8'd0;
          state_d  = StFillReq;
        end
      end
      StNextVd: begin
        if (vd_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          vd_d    = 1'b1;
          state_d = StSelectVd;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Transfer buffer: not reset; port B written by the fill, port A read by the HPS.
  always_ff @(posedge clk_sys) begin
    if (buf_we) buf_mem[idx_q] <= bus_io.mem_dout;
    buf_rdata_q <= buf_mem[bus_io.sd_buff_addr];
  end

  assign bus_io.sd_lba      = sd_lba_q;
  assign bus_io.sd_wr       = sd_wr_q;
  assign bus_io.sd_buff_din = buf_rdata_q;
  assign bus_io.mem_raddr   = mem_raddr_q;
  assign bus_io.mem_rd_req  = mem_rd_req_q;
  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.done        = done_q;

endmodule

// File: tb/tb_bk_save_ctrl.sv
// Bench for bk_save_ctrl: SDRAM and HPS models with logs, compared against
// transfer lists computed from the volume/block rules.
module tb_bk_save_ctrl;
  localparam logic [24:0] SramBase = 25'h100000;
  localparam logic [24:0] BmpBase  = 25'h140000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bk_save_if bif ();

  bk_save_ctrl #(
    .SRAM_BASE_A(SramBase),
    .BMP_BASE_A (BmpBase)
  ) dut (
    .clk_sys(clk),
    .reset  (reset),
    .bus_io (bif)
  );

  int total = 0;
  int bad   = 0;

  // SDRAM model: answers each toggle after 1 or 1..20 cycles with address[16:1].
  logic        lat_mode = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [24:0] paddr = '0;
  logic        prev_req = 1'b0;
  logic        prev_out = 1'b0;
  int          viol_toggle = 0;
  int          viol_addr = 0;
  int          viol_wr = 0;
  int          done_cnt = 0;
  logic [24:0] rd_q[$];

  always @(posedge clk) begin
    if (bif.done) done_cnt <= done_cnt + 1;
    if (bif.sd_wr == 2'b11 || (bif.sd_wr != 2'b00 && bif.mem_rd_req != bif.mem_rd_ack))
      viol_wr <= viol_wr + 1;
    if (reset) begin
      bif.mem_rd_ack <= 1'b0;
      pend           <= 1'b0;
      prev_req       <= 1'b0;
      prev_out       <= 1'b0;
    end else begin
      prev_req <= bif.mem_rd_req;
      prev_out <= (bif.mem_rd_req != bif.mem_rd_ack);
      if (bif.mem_rd_req != prev_req && prev_out) viol_toggle <= viol_toggle + 1;
      if (!pend && bif.mem_rd_req != bif.mem_rd_ack) begin
        pend  <= 1'b1;
        cnt   <= lat_mode ? int'($urandom_range(1, 20)) : 1;
        paddr <= bif.mem_raddr;
      end else if (pend) begin
        if (bif.mem_raddr != paddr) viol_addr <= viol_addr + 1;
        if (cnt <= 1) begin
          bif.mem_rd_ack <= bif.mem_rd_req;
          bif.mem_dout   <= paddr[16:1];
          pend           <= 1'b0;
          rd_q.push_back(paddr);
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // HPS model: logs each write request, then acks while reading out all 256 words.
  logic [33:0] wr_log[$];
  int          wr_at[$];
  logic [15:0] buf_log[$];
  int          wr_stuck = 0;
  logic [1:0]  hps_bits;

  initial begin
    bif.sd_ack       = 2'b00;
    bif.sd_buff_addr = 8'd0;
    forever begin
      @(posedge clk); #1;
      if (!reset && bif.sd_wr != 2'b00) begin
        wr_log.push_back({bif.sd_wr, bif.sd_lba});
        wr_at.push_back(rd_q.size());
        hps_bits = bif.sd_wr;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        bif.sd_ack       = hps_bits;
        bif.sd_buff_addr = 8'd0;
        @(posedge clk); #1;
        for (int i = 1; i <= 256; i++) begin
          buf_log.push_back(bif.sd_buff_din);
          if (i >= 2 && bif.sd_wr != 2'b00) wr_stuck++;
          if (i < 256) bif.sd_buff_addr = 8'(i);
          @(posedge clk); #1;
        end
        bif.sd_ack = 2'b00;
      end
    end
  end

  // Reference: expected read addresses and write requests, in transfer order.
  logic [24:0] exp_rd[$];
  logic [33:0] exp_wr[$];
  int rs, ws, bs, ds, vs_t, vs_a, vs_w, vs_s, n, e, cyc;
  bit tmo;

  task automatic build_exp(input logic [1:0] mounted, input int b0, input int b1);
    logic [31:0] a;
    int blocks;
    exp_rd.delete();
    exp_wr.delete();
    for (int v = 0; v < 2; v++) begin
      blocks = (v == 1) ? b1 : b0;
      if (mounted[v] && blocks != 0) begin
        for (int l = 0; l < blocks; l++) begin
          exp_wr.push_back({(v == 1) ? 2'b10 : 2'b01, 32'(l)});
          for (int i = 0; i < 256; i++) begin
            a = {7'b0, (v == 1) ? BmpBase : SramBase} + 32'(l) * 32'd512 + 32'(2 * i);
            exp_rd.push_back(a[24:0]);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic snap();
    rs = rd_q.size(); ws = wr_log.size(); bs = buf_log.size(); ds = done_cnt;
    vs_t = viol_toggle; vs_a = viol_addr; vs_w = viol_wr; vs_s = wr_stuck;
  endtask

  // Pulses bk_save and waits for done; optionally re-pulses bk_save while busy.
  task automatic save(input int limit, input bit poke);
    @(posedge clk); #1;
    bif.bk_save = 1'b1;
    @(posedge clk); #1;
    bif.bk_save = 1'b0;
    cyc = 1;
    tmo = 1'b1;
    while (cyc < limit) begin
      if (bif.done) begin
        tmo = 1'b0;
        break;
      end
      bif.bk_save = (poke && cyc == 50);
      @(posedge clk); #1;
      cyc++;
    end
    bif.bk_save = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bif.bk_save = 1'b0; bif.img_mounted = 2'b00;
    bif.vol0_blocks = 32'd0; bif.vol1_blocks = 32'd0;
    do_reset();
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bif.busy); end
    total++; if (bif.sd_wr !== 2'b00) begin bad++; $display("FAIL rst_sd_wr got=%b want=00", bif.sd_wr); end
    total++; if (bif.mem_rd_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", bif.mem_rd_req); end
    total++; if (bif.sd_lba !== 32'd0) begin bad++; $display("FAIL rst_lba got=%0d want=0", bif.sd_lba); end
    total++; if (bif.mem_raddr !== 25'd0) begin bad++; $display("FAIL rst_raddr got=%h want=0", bif.mem_raddr); end
    total++; if (bif.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bif.done); end
  endtask

  task automatic test_single_volume();
    bif.img_mounted = 2'b01; bif.vol0_blocks = 32'd2; bif.vol1_blocks = $urandom_range(0, 3);
    build_exp(2'b01, 2, 0);
    snap();
    save(8000, 1'b0);
    total++; if (tmo) begin bad++; $display("FAIL single_done got=timeout want=done"); end
    total++; if (done_cnt - ds !== 1) begin bad++; $display("FAIL single_done_cnt got=%0d want=1", done_cnt - ds); end
    n = rd_q.size() - rs; total++;
    if (n !== exp_rd.size()) begin bad++; $display("FAIL single_rd_cnt got=%0d want=%0d", n, exp_rd.size()); end
    else begin
      e = -1; for (int i = 0; i < n; i++) if (e < 0 && rd_q[rs+i] !== exp_rd[i]) e = i;
      total++; if (e >= 0) begin bad++; $display("FAIL single_rd_addr idx=%0d got=%h want=%h", e, rd_q[rs+e], exp_rd[e]); end
    end
    n = wr_log.size() - ws; total++;
    if (n !== exp_wr.size()) begin bad++; $display("FAIL single_wr_cnt got=%0d want=%0d", n, exp_wr.size()); end
    else begin
      e = -1; for (int i = 0; i < n; i++) if (e < 0 && wr_log[ws+i] !== exp_wr[i]) e = i;
      total++; if (e >= 0) begin bad++; $display("FAIL single_wr idx=%0d got=%h want=%h", e, wr_log[ws+e], exp_wr[e]); end
    end
    n = buf_log.size() - bs; total++;
    if (n !== exp_rd.size()) begin bad++; $display("FAIL single_buf_cnt got=%0d want=%0d", n, exp_rd.size()); end
    else begin
      e = -1; for (int i = 0; i < n; i++) if (e < 0 && buf_log[bs+i] !== exp_rd[i][16:1]) e = i;
      total++; if (e >= 0) begin bad++; $display("FAIL single_buf idx=%0d got=%h want=%h", e, buf_log[bs+e], exp_rd[e][16:1]); end
    end
  endtask

  task automatic test_both_volumes();
    bif.img_mounted = 2'b11; bif.vol0_blocks = 32'd1; bif.vol1_blocks = 32'd1;
    build_exp(2'b11, 1, 1);
    snap();
    save(8000, 1'b0);
    total++; if (tmo) begin bad++; $display("FAIL both_done got=timeout want=done"); end
    n = rd_q.size() - rs; total++;
    if (n !== exp_rd.size()) begin bad++; $display("FAIL both_rd_cnt got=%0d want=%0d", n, exp_rd.size()); end
    else begin
      e = -1; for (int i = 0; i < n; i++) if (e < 0 && rd_q[rs+i] !== exp_rd[i]) e = i;
      total++; if (e >= 0) begin bad++; $display("FAIL both_rd_addr idx=%0d got=%h want=%h", e, rd_q[rs+e], exp_rd[e]); end
    end
    n = wr_log.size() - ws; total++;
    if (n !== 2) begin bad++; $display("FAIL both_wr_cnt got=%0d want=2", n); end
    else begin
      total++; if (wr_log[ws] !== exp_wr[0] || wr_log[ws+1] !== exp_wr[1]) begin
        bad++; $display("FAIL both_wr got=%h,%h want=%h,%h", wr_log[ws], wr_log[ws+1], exp_wr[0], exp_wr[1]);
      end
      total++; if (wr_at[ws] - rs !== 256) begin
        bad++; $display("FAIL both_wr0_order reads_before=%0d want=256", wr_at[ws] - rs);
      end
    end
  endtask

  task automatic test_random_latency();
    logic [1:0] m;
    int b0, b1;
    lat_mode = 1'b1;
    for (int r = 0; r < 2; r++) begin
      m  = 2'($urandom_range(1, 3));
      b0 = $urandom_range(0, 2);
      b1 = $urandom_range(0, 1);
      bif.img_mounted = m; bif.vol0_blocks = 32'(b0); bif.vol1_blocks = 32'(b1);
      build_exp(m, b0, b1);
      snap();
      save(30000, 1'b1);
      total++; if (tmo) begin bad++; $display("FAIL rnd_done got=timeout want=done"); end
      total++; if (done_cnt - ds !== 1) begin bad++; $display("FAIL rnd_done_cnt got=%0d want=1", done_cnt - ds); end
      n = rd_q.size() - rs; total++;
      if (n !== exp_rd.size()) begin bad++; $display("FAIL rnd_rd_cnt got=%0d want=%0d", n, exp_rd.size()); end
      else begin
        e = -1; for (int i = 0; i < n; i++) if (e < 0 && rd_q[rs+i] !== exp_rd[i]) e = i;
        total++; if (e >= 0) begin bad++; $display("FAIL rnd_rd_addr idx=%0d got=%h want=%h", e, rd_q[rs+e], exp_rd[e]); end
        e = -1; for (int i = 0; i < n; i++) if (e < 0 && buf_log.size() > bs + i && buf_log[bs+i] !== exp_rd[i][16:1]) e = i;
        total++; if (e >= 0) begin bad++; $display("FAIL rnd_buf idx=%0d got=%h want=%h", e, buf_log[bs+e], exp_rd[e][16:1]); end
      end
      n = wr_log.size() - ws; total++;
      if (n !== exp_wr.size()) begin bad++; $display("FAIL rnd_wr_cnt got=%0d want=%0d", n, exp_wr.size()); end
      else begin
        e = -1; for (int i = 0; i < n; i++) if (e < 0 && wr_log[ws+i] !== exp_wr[i]) e = i;
        total++; if (e >= 0) begin bad++; $display("FAIL rnd_wr idx=%0d got=%h want=%h", e, wr_log[ws+e], exp_wr[e]); end
      end
      total++; if (viol_toggle - vs_t !== 0) begin bad++; $display("FAIL rnd_toggle got=%0d want=0", viol_toggle - vs_t); end
      total++; if (viol_addr - vs_a !== 0) begin bad++; $display("FAIL rnd_raddr_stable got=%0d want=0", viol_addr - vs_a); end
      total++; if (viol_wr - vs_w !== 0) begin bad++; $display("FAIL rnd_sd_wr_excl got=%0d want=0", viol_wr - vs_w); end
      total++; if (wr_stuck - vs_s !== 0) begin bad++; $display("FAIL rnd_sd_wr_clear got=%0d want=0", wr_stuck - vs_s); end
    end
    lat_mode = 1'b0;
  endtask

  task automatic test_no_volume();
    for (int r = 0; r < 2; r++) begin
      bif.img_mounted = (r == 0) ? 2'b00 : 2'b01;
      bif.vol0_blocks = (r == 0) ? 32'd3 : 32'd0;
      bif.vol1_blocks = 32'd3;
      snap();
      save(7, 1'b0);
      total++; if (tmo) begin bad++; $display("FAIL empty_done case=%0d got=late want=within6", r); end
      total++; if (rd_q.size() - rs !== 0) begin bad++; $display("FAIL empty_reads case=%0d got=%0d want=0", r, rd_q.size() - rs); end
      total++; if (wr_log.size() - ws !== 0) begin bad++; $display("FAIL empty_wr case=%0d got=%0d want=0", r, wr_log.size() - ws); end
    end
  endtask

  task automatic test_reset_mid_fill();
    int k;
    bif.img_mounted = 2'b01; bif.vol0_blocks = 32'd2; bif.vol1_blocks = 32'd0;
    snap();
    @(posedge clk); #1;
    bif.bk_save = 1'b1;
    @(posedge clk); #1;
    bif.bk_save = 1'b0;
    k = 0;
    while (rd_q.size() - rs < 100 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    total++; if (k >= 3000) begin bad++; $display("FAIL midrst_reach got=%0d want=100", rd_q.size() - rs); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", bif.busy); end
    total++; if (bif.sd_wr !== 2'b00) begin bad++; $display("FAIL midrst_sd_wr got=%b want=00", bif.sd_wr); end
    total++; if (bif.mem_rd_req !== 1'b0) begin bad++; $display("FAIL midrst_req got=%b want=0", bif.mem_rd_req); end
    total++; if (bif.mem_raddr !== 25'd0) begin bad++; $display("FAIL midrst_raddr got=%h want=0", bif.mem_raddr); end
    reset = 1'b0;
    @(posedge clk); #1;
    bif.vol0_blocks = 32'd1;
    build_exp(2'b01, 1, 0);
    snap();
    save(4000, 1'b0);
    total++; if (tmo) begin bad++; $display("FAIL midrst_done got=timeout want=done"); end
    n = rd_q.size() - rs; total++;
    if (n !== exp_rd.size()) begin bad++; $display("FAIL midrst_rd_cnt got=%0d want=%0d", n, exp_rd.size()); end
    else begin
      e = -1; for (int i = 0; i < n; i++) if (e < 0 && rd_q[rs+i] !== exp_rd[i]) e = i;
      total++; if (e >= 0) begin bad++; $display("FAIL midrst_rd_addr idx=%0d got=%h want=%h", e, rd_q[rs+e], exp_rd[e]); end
    end
    total++; if (wr_log.size() - ws !== 1 || wr_log[wr_log.size()-1] !== exp_wr[0]) begin
      bad++; $display("FAIL midrst_wr got_cnt=%0d want=1 at lba 0", wr_log.size() - ws);
    end
  endtask

  initial begin
    reset = 1'b1;
    bif.bk_save = 1'b0;
    test_reset();
    test_single_volume();
    test_both_volumes();
    test_random_latency();
    test_no_volume();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bk_save_ctrl.md
BK_SAVE_CTRL -- requirements
Module: bk_save_ctrl

Interface
REQ-001 SHALL have parameter SRAM_BASE_A, default 25'h0, the SDRAM byte address of volume 0 (backup SRAM) image.
REQ-002 SHALL have parameter BMP_BASE_A, default 25'h0, the SDRAM byte address of volume 1 (BMP card) image.
REQ-003 SHALL have port clk_sys, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port bk_save, input, 1, save request; sampled only in IDLE.
REQ-006 SHALL have port img_mounted, input, 2, per-volume mounted level.
REQ-007 SHALL have ports vol0_blocks and vol1_blocks, input, 32 each, image length in 512-byte blocks.
REQ-008 SHALL have port sd_lba, output, 32, current block number.
REQ-009 SHALL have port sd_wr, output, 2, per-volume write request to the HPS.
REQ-010 SHALL have port sd_ack, input, 2, HPS acknowledge.
REQ-011 SHALL have port sd_buff_addr, input, 8, HPS halfword index into the transfer buffer.
REQ-012 SHALL have port sd_buff_din, output, 16, buffer data to the HPS.
REQ-013 SHALL have port mem_raddr, output, 25, SDRAM byte address, always halfword aligned.
REQ-014 SHALL have port mem_rd_req, output, 1, toggle read request.
REQ-015 SHALL have port mem_rd_ack, input, 1, toggle acknowledge.
REQ-016 SHALL have port mem_dout, input, 16, read data, valid when mem_rd_ack equals mem_rd_req.
REQ-017 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-018 SHALL have port done, output, 1, single-cycle pulse on return to IDLE after a save.

Function
REQ-019 SHALL contain a 256x16 dual-port transfer buffer.
REQ-020 Buffer port A SHALL be read by sd_buff_addr, with sd_buff_din registered one cycle later.
REQ-021 Buffer port B SHALL be written only by the fill logic.
REQ-022 FSM states SHALL be IDLE, SELECT_VD, FILL_REQ, FILL_WAIT, START_SD_WR, SD_WR, NEXT_LBA, NEXT_VD.
REQ-023 IDLE: on bk_save=1, set vd<=0 and go to SELECT_VD.
REQ-024 IDLE: while busy, bk_save SHALL be ignored.
REQ-025 SELECT_VD: if img_mounted[vd]=1 and the selected block count is nonzero, clear sd_lba and the word index and go to FILL_REQ.
REQ-026 SELECT_VD: otherwise go to NEXT_VD.
REQ-027 FILL_REQ: drive mem_raddr = base(vd) + {sd_lba,9'b0} + {idx,1'b0}, truncated to 25 bits.
REQ-028 FILL_REQ: toggle mem_rd_req and go to FILL_WAIT.
REQ-029 FILL_WAIT: when mem_rd_ack equals mem_rd_req, write mem_dout to buffer[idx].
REQ-030 FILL_WAIT: on the same cycle, if idx=255 go to START_SD_WR, else increment idx and go to FILL_REQ.
REQ-031 mem_raddr SHALL be held stable while a request is outstanding.
REQ-032 START_SD_WR: set sd_wr[vd]<=1 and go to SD_WR.
REQ-033 SD_WR: on a rising edge of |sd_ack (registered copy), clear all sd_wr bits.
REQ-034 SD_WR: on a falling edge of |sd_ack, go to NEXT_LBA.
REQ-035 SD_WR: a simultaneous rise and fall SHALL be impossible because of the registered edge detect.
REQ-036 NEXT_LBA: if sd_lba+1 equals the block count, go to NEXT_VD.
REQ-037 NEXT_LBA: otherwise increment sd_lba, clear idx, and go to FILL_REQ.
REQ-038 The sd_lba+1 comparison SHALL use 32-bit arithmetic with no wrap handling.
REQ-039 NEXT_VD: if vd=1, go to IDLE and pulse done.
REQ-040 NEXT_VD: otherwise set vd<=1 and go to SELECT_VD.
REQ-041 img_mounted and block counts SHALL be sampled only in SELECT_VD and NEXT_LBA.
REQ-042 Unmounting during SD_WR SHALL NOT abort the transfer.
REQ-043 At most one sd_wr bit SHALL be high at any time.
REQ-044 sd_wr SHALL never be high during FILL_REQ or FILL_WAIT.
REQ-045 HPS reads of the buffer during a fill SHALL return undefined but stable data, with no side effects.

Reset
REQ-046 Reset SHALL force state IDLE from any state, including mid-fill and mid-SD write.
REQ-047 Reset SHALL set sd_wr=0, mem_rd_req=0, sd_lba=0, mem_raddr=0, busy=0, done=0, vd=0, idx=0.
REQ-048 The memory side SHALL share reset so that mem_rd_ack also returns to 0.
REQ-049 Buffer contents SHALL NOT be reset.

Verification
REQ-050 Scenario: vol0 mounted, vol0_blocks=2, vol1 unmounted, SRAM_BASE_A=25'h100000, pulse bk_save -> 512 reads at 0x100000..0x1003FE step 2; sd_wr=2'b01 twice with sd_lba 0 then 1; done pulses once.
REQ-051 Scenario: both volumes mounted, 1 block each, BMP_BASE_A=25'h140000 -> vol0 block fully written before any read at 0x140000; second write on sd_wr=2'b10.
REQ-052 Scenario: memory model returns halfword = address[16:1]; HPS reads sd_buff_addr 0..255 after sd_wr rises -> sd_buff_din = base/2 + index, one cycle after address.
REQ-053 Scenario: memory ack delayed by random 1-20 cycles -> no request toggles while one is outstanding; mem_raddr stable throughout.
REQ-054 Scenario: reset asserted at idx=100 of block 0 -> next cycle busy=0, sd_wr=0, mem_rd_req=0; a new bk_save restarts at sd_lba=0, idx=0.
REQ-055 Scenario: bk_save with no volumes mounted, or vol0_blocks=0 -> no memory reads, no sd_wr; done pulses within 6 cycles.
